// File: rtl/sha3_stream_feeder_pkg.sv
// sha3_feeder_pkg: shared state encoding, LFSR taps and digest fold helper for the SHA3 stream feeder
package sha3_feeder_pkg;
  typedef enum logic [2:0] {S_IDLE, S_CLR, S_SEND, S_LAST, S_WAIT, S_CAPTURE} state_t;
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam int FOLD_W = 32;
  function automatic logic [FOLD_W-1:0] fold_digest(input logic [511:0] d);
    fold_digest = '0;
    for (int i = 0; i < 512 / FOLD_W; i++) fold_digest ^= d[i*FOLD_W +: FOLD_W];
  endfunction
endpackage

// File: rtl/sha3_stream_feeder_if.sv
// sha3_stream_feeder_if: word-input and digest signals between the feeder (master) and the SHA3 core (slave)
interface sha3_stream_feeder_if;
  logic         sha3_reset;
  logic [31:0]  sha3_in;
  logic         sha3_in_ready;
  logic         sha3_is_last;
  logic [1:0]   sha3_byte_num;
  logic         sha3_buffer_full;
  logic [511:0] sha3_out;
  logic         sha3_out_ready;
  modport master (
    output sha3_reset, sha3_in, sha3_in_ready, sha3_is_last, sha3_byte_num,
    input  sha3_buffer_full, sha3_out, sha3_out_ready
  );
  modport slave (
    input  sha3_reset, sha3_in, sha3_in_ready, sha3_is_last, sha3_byte_num,
    output sha3_buffer_full, sha3_out, sha3_out_ready
  );
endinterface

// File: rtl/sha3_stream_feeder_lfsr.sv
// galois_lfsr32: 32-bit right-shifting Galois LFSR with synchronous load and advance
module galois_lfsr32 import sha3_feeder_pkg::*; #(
  parameter logic [31:0] SEED = 32'hACE1_0001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        adv_i,
  output logic [31:0] value_o
);
  logic [31:0] lfsr_q, lfsr_d;
  always_comb lfsr_d = load_i ? SEED : adv_i ? ((lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 32'h0)) : lfsr_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lfsr_q <= SEED;
    else lfsr_q <= lfsr_d;
  assign value_o = lfsr_q;
endmodule

// File: rtl/sha3_stream_feeder.sv
// sha3_stream_feeder: streams an LFSR message into the SHA3 core and folds the returned digest into a signature
module sha3_stream_feeder import sha3_feeder_pkg::*; #(
  parameter int          MAX_BYTES = 1024,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_0001,
  parameter int          TIMEOUT   = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [15:0]          msg_bytes_i,
  sha3_stream_feeder_if.master core,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o,
  output logic [FOLD_W-1:0]    digest_sig_o,
  output logic [15:0]          msg_count_o
);
  localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  state_t            state_q, state_d;
  logic [15:0]       words_q, words_d, cnt_q, cnt_d, len;
  logic [1:0]        rem_q, rem_d;
  logic [TW-1:0]     wait_q, wait_d;
  logic              done_q, done_d, error_q, error_d, load, issue;
  logic [FOLD_W-1:0] sig_q, sig_d;
  logic [31:0]       lfsr;
  galois_lfsr32 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk(clk), .rst_n(rst_n), .load_i(load), .adv_i(issue), .value_o(lfsr)
  );
  assign len   = msg_bytes_i > 16'(MAX_BYTES) ? 16'(MAX_BYTES) : msg_bytes_i;
  assign issue = core.sha3_in_ready;
  assign core.sha3_reset    = state_q == S_CLR;
  assign core.sha3_in_ready = (state_q == S_SEND || state_q == S_LAST) && !core.sha3_buffer_full;
  assign core.sha3_is_last  = state_q == S_LAST && core.sha3_in_ready;
  assign core.sha3_byte_num = core.sha3_is_last ? rem_q : 2'd0;
  // final word keeps only the top rem bytes; rem=0 yields an all-zero word
  assign core.sha3_in = state_q == S_SEND ? lfsr
                      : state_q == S_LAST ? lfsr & ~(32'hFFFF_FFFF >> {rem_q, 3'b000}) : 32'h0;
  assign busy_o       = state_q != S_IDLE;
  assign done_o       = done_q;
  assign error_o      = error_q;
  assign digest_sig_o = sig_q;
  assign msg_count_o  = cnt_q;
  always_comb begin
    state_d = state_q;
    words_d = words_q;
    rem_d   = rem_q;
    wait_d  = wait_q;
    done_d  = 1'b0;
    error_d = error_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    case (state_q)
      S_IDLE: if (start_i) begin
        words_d = {2'b00, len[15:2]};
        rem_d   = len[1:0];
        error_d = 1'b0;
        load    = 1'b1;
        state_d = S_CLR;
      end
      S_CLR: state_d = words_q != '0 ? S_SEND : S_LAST;
      S_SEND: if (issue) begin
        words_d = words_q - 16'd1;
        state_d = words_q == 16'd1 ? S_LAST : S_SEND;
      end
      S_LAST: if (issue) begin
        wait_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: if (core.sha3_out_ready) state_d = S_CAPTURE;
        else if (wait_q == TW'(TIMEOUT - 1)) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end else wait_d = wait_q + 1'b1;
      S_CAPTURE: begin
        sig_d   = fold_digest(core.sha3_out);
        done_d  = 1'b1;
        cnt_d   = cnt_q + 16'd1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      words_q <= '0;
      rem_q   <= '0;
      wait_q  <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      sig_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      words_q <= words_d;
      rem_q   <= rem_d;
      wait_q  <= wait_d;
      done_q  <= done_d;
      error_q <= error_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
    end
endmodule

// File: tb/tb_sha3_stream_feeder.sv
// tb_sha3_stream_feeder: vector table plus randomized messages checked against a message-level model of the feeder
module tb_sha3_stream_feeder;
  localparam logic [31:0] SEED = 32'hACE1_0001;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [15:0] msg_bytes = '0;
  logic        busy, done, error;
  logic [31:0] sig;
  logic [15:0] mcnt, cnt_exp = '0;
  int          n_cmp = 0, n_bad = 0;
  sha3_stream_feeder_if core();
  sha3_stream_feeder #(.MAX_BYTES(1024), .LFSR_SEED(SEED), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .msg_bytes_i(msg_bytes), .core(core),
    .busy_o(busy), .done_o(done), .error_o(error), .digest_sig_o(sig), .msg_count_o(mcnt)
  );
  always #5 clk = ~clk;
  typedef struct {int bytes; int slo; int shi; bit rnd; bit respond; bit extra; int exp_nl; int exp_bn;} vec_t;
  vec_t tbl[7];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask
  function automatic logic [31:0] nxt(input logic [31:0] v);
    return v[0] ? (v >> 1) ^ 32'h8020_0003 : v >> 1;
  endfunction
  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ctl"}, {busy, done, error, core.sha3_reset, core.sha3_in_ready, core.sha3_is_last, core.sha3_byte_num}, 0);
    chk({tag, "_data"}, {core.sha3_in, sig, mcnt}, 0);
  endtask
  task automatic run_msg(input int bytes, input int slo, input int shi, input bit rnd,
                         input bit respond, input bit extra, output int nonlast, output int bnum);
    logic [34:0]  got_q[$], want_q[$];
    logic [31:0]  v, lw, f;
    logic [511:0] dg;
    int len, nw, rem, clr, last_cyc, k;
    bit fin;
    len = bytes > 1024 ? 1024 : bytes;
    nw  = len / 4;
    rem = len % 4;
    v   = SEED;
    for (int i = 0; i < nw; i++) begin
      want_q.push_back({1'b0, 2'b00, v});
      v = nxt(v);
    end
    lw = '0;
    for (int b = 0; b < rem; b++) lw[31-8*b -: 8] = v[31-8*b -: 8];
    want_q.push_back({1'b1, 2'(rem), lw});
    @(posedge clk); #1 start = 1'b1; msg_bytes = 16'(bytes);
    @(posedge clk); #1 start = 1'b0;
    clr = 0; fin = 1'b0; last_cyc = -1;
    for (int cyc = -1; cyc < 3000 && !fin; cyc++) begin
      @(negedge clk);
      if (cyc == -1) begin
        chk("clr_timing", core.sha3_reset, 1);
        chk("err_cleared", error, 0);
      end
      if (core.sha3_reset) begin
        clr++;
        core.sha3_out_ready = 1'b0;
      end
      if (core.sha3_in_ready) begin
        if (core.sha3_buffer_full) chk("ready_while_full", 1, 0);
        got_q.push_back({core.sha3_is_last, core.sha3_byte_num, core.sha3_in});
        if (core.sha3_is_last) begin
          fin = 1'b1;
          last_cyc = cyc;
        end
      end else chk("last_gated", {core.sha3_is_last, core.sha3_byte_num}, 0);
      @(posedge clk); #1;
      core.sha3_buffer_full = rnd ? ($urandom_range(0, 2) == 0) : (cyc + 1 >= slo && cyc + 1 <= shi);
      start     = extra && cyc == 4;
      msg_bytes = (extra && cyc == 4) ? 16'd8 : 16'(bytes);
    end
    start = 1'b0;
    core.sha3_buffer_full = 1'b0;
    chk("last_word_seen", fin, 1);
    chk("clr_count", clr, 1);
    if (!rnd && shi < slo) chk("last_timing", last_cyc, nw);
    chk("word_count", got_q.size(), want_q.size());
    nonlast = 0;
    bnum = -1;
    for (int i = 0; i < got_q.size(); i++) begin
      if (i < want_q.size()) chk("word", got_q[i], want_q[i]);
      if (!got_q[i][34]) nonlast++;
      else bnum = int'(got_q[i][33:32]);
    end
    if (respond) begin
      k = $urandom_range(0, 4);
      repeat (k) begin
        @(negedge clk); chk("no_early_done", done, 0);
        @(posedge clk); #1;
      end
      for (int i = 0; i < 16; i++) dg[i*32 +: 32] = $urandom;
      f = '0;
      for (int i = 0; i < 16; i++) f ^= dg[i*32 +: 32];
      core.sha3_out = dg;
      core.sha3_out_ready = 1'b1;
      cnt_exp = cnt_exp + 16'd1;
      @(negedge clk); chk("done_pre", done, 0);
      @(negedge clk); chk("done_capture", done, 0); chk("busy_capture", busy, 1);
      @(negedge clk);
      chk("done_pulse", done, 1);
      chk("digest_sig", sig, f);
      chk("msg_count", mcnt, cnt_exp);
      chk("idle_after_done", busy, 0);
      @(negedge clk); chk("done_width", done, 0);
    end else begin
      for (int i = 1; i <= 17; i++) begin
        @(negedge clk);
        chk("no_done", done, 0);
        if (i == 16) chk("err_early", error, 0);
        if (i == 17) begin
          chk("err_timeout", error, 1);
          chk("idle_after_timeout", busy, 0);
          chk("count_hold", mcnt, cnt_exp);
        end
      end
    end
  endtask
  initial begin
    int nl, bn;
    core.sha3_buffer_full = 1'b0;
    core.sha3_out_ready   = 1'b0;
    core.sha3_out         = '0;
    tbl[0] = '{0,    1,  0,  1'b0, 1'b1, 1'b0, 0,   0};
    tbl[1] = '{7,    1,  0,  1'b0, 1'b1, 1'b0, 1,   3};
    tbl[2] = '{12,   1,  3,  1'b0, 1'b1, 1'b0, 3,   0};
    tbl[3] = '{9,    1,  0,  1'b0, 1'b0, 1'b0, 2,   1};
    tbl[4] = '{5,    0,  0,  1'b0, 1'b1, 1'b0, 1,   1};
    tbl[5] = '{2000, 1,  0,  1'b0, 1'b1, 1'b1, 256, 0};
    tbl[6] = '{1023, 10, 12, 1'b0, 1'b1, 1'b0, 255, 3};
    #12 chk_idle_outputs("reset_state");
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk); chk_idle_outputs("after_release");
    for (int t = 0; t < 7; t++) begin
      run_msg(tbl[t].bytes, tbl[t].slo, tbl[t].shi, tbl[t].rnd, tbl[t].respond, tbl[t].extra, nl, bn);
      chk("tbl_nonlast", nl, tbl[t].exp_nl);
      chk("tbl_byte_num", bn, tbl[t].exp_bn);
    end
    @(posedge clk); #1 start = 1'b1; msg_bytes = 16'd40;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("send_active", {busy, core.sha3_in_ready}, 2'b11);
    #2 rst_n = 1'b0;
    #1 chk_idle_outputs("async_reset");
    cnt_exp = '0;
    @(posedge clk); #1 rst_n = 1'b1;
    run_msg(6, 1, 0, 1'b0, 1'b1, 1'b0, nl, bn);
    chk("post_reset_bnum", bn, 2);
    for (int r = 0; r < 6; r++) begin
      int b;
      b = $urandom_range(0, 70);
      run_msg(b, 1, 0, 1'b1, 1'b1, 1'b0, nl, bn);
      chk("rnd_nonlast", nl, b / 4);
      chk("rnd_byte_num", bn, b % 4);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
